insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Streaming MIPS-lite instruction encoder: the inverse of the control decoder.
//  Accepts (op, rs, rt, rd, imm, target) tuples over a valid/ready handshake and packs them into 32-bit words.
//  Writes the words sequentially into instruction memory through a registered write port.
//  Used by the boot/self-test loader to build programs for the single-cycle core.
// PARAMETERS
//  ADDR_W     32         im_addr width; byte address, word-aligned
//  RST_ADDR   32'h3000   im_addr value after reset
// PORTS
//  clk         in   1       single clock; all logic on rising edge
//  rst_n       in   1       synchronous, active-low reset
//  base_load   in   1       load base_addr into write pointer (honoured only in S_EMPTY)
//  base_addr   in   ADDR_W  new write pointer; bits[1:0] forced to 0
//  in_valid    in   1       instruction tuple valid
//  in_ready    out  1       tuple accepted when in_valid & in_ready
//  in_op       in   4       OP_ADDU=0 SUBU=1 ORI=2 LW=3 SW=4 BEQ=5 LUI=6 J=7; 8..15 illegal
//  in_rs/rt/rd in   5 each  register fields
//  in_imm      in   16      immediate / branch offset
//  in_target   in   26      jump target field
//  im_we       out  1       write request; held until im_ready
//  im_ready    in   1       memory accepts write this cycle
//  im_addr     out  ADDR_W  write address
//  im_wdata    out  32      encoded word
//  word_cnt    out  16      words written since reset; wraps at 2^16
//  err_illegal out  1       one-cycle pulse on accepted illegal op
// BEHAVIOUR
//  Reset: state=S_EMPTY, im_we=0, im_wdata=0, im_addr=RST_ADDR, word_cnt=0, err_illegal=0. in_ready=1 out of reset.
//  Encoding (combinational, registered into im_wdata):
//   ADDU {00,rs,rt,rd,0,21}; SUBU {00,rs,rt,rd,0,23}; ORI {0d,rs,rt,imm}; LW {23,rs,rt,imm}
//   SW {2b,rs,rt,imm}; BEQ {04,rs,rt,imm}; LUI {0f,00000,rt,imm}; J {02,target}. Unused fields ignored.
//  FSM states: S_EMPTY, S_WORD (encoded word pending), S_NOP (delay-slot NOP pending; macro only).
//   S_EMPTY: accepted legal tuple -> S_WORD. im_we=0.
//   S_WORD: im_we=1. On im_ready, pending word retires -> S_NOP if it is BEQ/J and macro set.
//     Otherwise -> S_WORD if a new legal tuple is accepted the same cycle, else S_EMPTY.
//   S_NOP: im_we=1, im_wdata=0. On im_ready -> S_WORD if tuple accepted, else S_EMPTY.
//  in_ready = S_EMPTY | (im_ready & ~(S_WORD & branch_pending & macro)); no bubble on back-to-back stream.
//  Latency: tuple accepted at edge N -> im_we/im_wdata valid at N+1.
//  Retire (im_we & im_ready): im_addr += 4 (wraps mod 2^ADDR_W); word_cnt += 1.
//  im_we held with stable im_addr/im_wdata until im_ready; never dropped.
//  Illegal op: tuple is consumed (in_ready per rule above). No word is produced; state, im_addr and word_cnt are unchanged.
//   err_illegal=1 in the following cycle only.
//  base_load in S_EMPTY: im_addr<=base_addr & ~3 next cycle. Priority over a tuple accepted the same cycle: that tuple's word uses the new base.
//   base_load outside S_EMPTY: ignored.
//  rst_n low mid-write: pending word discarded, all outputs to reset values next edge.
// CONFIGURATION
//  ENC_DELAY_SLOT_EN defined: after each BEQ/J word retires, a NOP (32'h0) is written at the next address.
//   In that case in_ready=0 for the retire cycle, and word_cnt counts the NOP.
//  Undefined: S_NOP unreachable/removed; BEQ/J followed directly by the next tuple.
// STRUCTURE
//  Package mips_lite_pkg: OP_* 4-bit op codes; OPC_* 6-bit opcodes (00,0d,23,2b,04,0f,02); FUNCT_ADDU=21, FUNCT_SUBU=23; state encodings.
//   Shared with the control decoder.
//  Sub-module insn_pack: combinational op+fields -> {legal, is_branch, word[31:0]}.
//  Top holds FSM, output register, address pointer, counter.
// TESTING
//  1 ADDU rs=1 rt=2 rd=3 after reset -> im_we@+1, im_addr=0x3000, im_wdata=0x00221821; after im_ready: word_cnt=1.
//  2 Stream ORI rs=0 rt=1 imm=0x1234, LUI rt=4 imm=0xABCD, LW rs=2 rt=5 imm=4, im_ready=1 constant:
//    -> 0x34011234@0x3000, 0x3C04ABCD@0x3004, 0x8C450004@0x3008, in_ready never low.
//  3 im_ready=0 for 3 cycles with word pending -> im_we, im_addr, im_wdata stable; in_ready=0; no tuple lost.
//  4 in_op=9 -> err_illegal pulse 1 cycle, no im_we, word_cnt and im_addr unchanged.
//  5 ENC_DELAY_SLOT_EN: BEQ rs=1 rt=2 imm=0xFFFF then J target=0x10
//    -> 0x1022FFFF, 0x00000000, 0x08000010, 0x00000000 at consecutive addresses; without macro only the two words.
//  6 base_load base=0xFFFFFFFC, write two words -> addrs 0xFFFFFFFC then 0x00000000 (wrap); rst_n=0 mid-stall -> im_we=0, im_addr=0x3000.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: op codes, opcodes, function codes and encoder state encodings
// shared by the MIPS-lite control decoder and the instruction encoder.
package mips_lite_pkg;
    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_ORI  = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_SW   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_LUI  = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    typedef enum logic [1:0] {S_EMPTY, S_WORD, S_NOP} enc_state_t;
endpackage

// File: rtl/insn_pack.sv
// insn_pack: combinational packing of an op and its fields into a 32-bit word.
//   op, rs, rt, rd, imm, target  in   instruction tuple
//   legal                        out  op is one of the eight defined ops
//   is_branch                    out  op is BEQ or J (needs a delay slot when enabled)
//   word                         out  encoded instruction (0 for illegal ops)
module insn_pack
    import mips_lite_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic        is_branch,
    output logic [31:0] word
);
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (op)
            OP_ADDU: word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADDU};
            OP_SUBU: word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUBU};
            OP_ORI:  word = {OPC_ORI, rs, rt, imm};
            OP_LW:   word = {OPC_LW, rs, rt, imm};
            OP_SW:   word = {OPC_SW, rs, rt, imm};
            OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
            OP_LUI:  word = {OPC_LUI, 5'd0, rt, imm};
            OP_J:    word = {OPC_J, target};
            default: legal = 1'b0;
        endcase
    end

    assign is_branch = (op == OP_BEQ) || (op == OP_J);
endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: streams instruction tuples into encoded words written to
// instruction memory through a registered, held-until-accepted write port.
//   clk, rst_n                  clock, synchronous active-low reset
//   base_load, base_addr        reload write pointer (only while idle)
//   in_valid/in_ready, in_*     tuple handshake and fields
//   im_we/im_ready              write request / memory accept
//   im_addr, im_wdata           write address and encoded word
//   word_cnt                    words written since reset (wraps)
//   err_illegal                 one-cycle pulse after an accepted illegal op
// Build option: ENC_DELAY_SLOT_EN appends a NOP after every BEQ/J word.
module insn_encoder
    import mips_lite_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(32'h3000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       word_cnt,
    output logic              err_illegal
);
`ifdef ENC_DELAY_SLOT_EN
    localparam logic DS_EN = 1'b1;
`else
    localparam logic DS_EN = 1'b0;
`endif

    enc_state_t  state, state_nxt;
    logic        branch_pend;
    logic        legal, is_branch;
    logic [31:0] word;
    logic        accept, take, retire, to_nop;

    insn_pack u_pack (
        .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .imm(in_imm), .target(in_target),
        .legal(legal), .is_branch(is_branch), .word(word)
    );

    // A retiring branch word blocks intake for one cycle so its NOP goes next.
    assign to_nop   = (state == S_WORD) && im_ready && branch_pend && DS_EN;
    assign im_we    = state != S_EMPTY;
    assign in_ready = (state == S_EMPTY) || (im_ready && !((state == S_WORD) && branch_pend && DS_EN));
    assign accept   = in_valid && in_ready;
    assign take     = accept && legal;
    assign retire   = im_we && im_ready;

    always_comb begin
        state_nxt = state;
        if (state == S_EMPTY)
            state_nxt = take ? S_WORD : S_EMPTY;
        else if (im_ready)
            state_nxt = to_nop ? S_NOP : (take ? S_WORD : S_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            branch_pend <= 1'b0;
            im_addr     <= RST_ADDR;
            im_wdata    <= 32'h0;
            word_cnt    <= 16'd0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_illegal <= accept && !legal;
            if (retire) begin
                im_addr  <= im_addr + ADDR_W'(4);
                word_cnt <= word_cnt + 16'd1;
            end else if (base_load && state == S_EMPTY) begin
                im_addr <= base_addr & ~ADDR_W'(3);
            end
            if (to_nop) begin
                im_wdata <= 32'h0;
            end else if (take) begin
                im_wdata    <= word;
                branch_pend <= is_branch;
            end
        end
    end
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: randomized and directed checks of insn_encoder against a
// field-arithmetic encoding model and a queue of expected memory writes.
module tb_insn_encoder;
    logic        clk = 1'b0, rst_n = 1'b0, base_load = 1'b0, in_valid = 1'b0, im_ready = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'h0;
    logic [25:0] in_target = 26'h0;
    logic        in_ready, im_we, err_illegal;
    logic [31:0] im_addr, im_wdata;
    logic [15:0] word_cnt;

    int n_checks = 0, n_fail = 0;
`ifdef ENC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic [31:0] exp_q[$], got_d[$], got_a[$];
    logic        rdy_seen, ill_seen, stall_seen;
    logic [31:0] stall_addr, stall_data;

    insn_encoder dut (
        .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .word_cnt(word_cnt), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // {legal, word} built from the instruction format field positions.
    function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] r, t, d, i;
        r = 32'(rs) * 32'h0020_0000;
        t = 32'(rt) * 32'h0001_0000;
        d = 32'(rd) * 32'h0000_0800;
        i = 32'(imm);
        case (op)
            4'd0: return {1'b1, r + t + d + 32'd33};
            4'd1: return {1'b1, r + t + d + 32'd35};
            4'd2: return {1'b1, 32'd13 * 32'h0400_0000 + r + t + i};
            4'd3: return {1'b1, 32'd35 * 32'h0400_0000 + r + t + i};
            4'd4: return {1'b1, 32'd43 * 32'h0400_0000 + r + t + i};
            4'd5: return {1'b1, 32'd4  * 32'h0400_0000 + r + t + i};
            4'd6: return {1'b1, 32'd15 * 32'h0400_0000 + t + i};
            4'd7: return {1'b1, 32'd2  * 32'h0400_0000 + 32'(tgt)};
            default: return 33'h0;
        endcase
    endfunction

    // One clock: sample handshakes just before the edge, return after the next falling edge.
    task automatic step();
        logic [32:0] e;
        #4;
        rdy_seen   = in_ready;
        ill_seen   = 1'b0;
        stall_seen = im_we && !im_ready && rst_n;
        stall_addr = im_addr;
        stall_data = im_wdata;
        if (im_we && im_ready && rst_n) begin
            got_a.push_back(im_addr);
            got_d.push_back(im_wdata);
        end
        if (in_valid && in_ready && rst_n) begin
            e = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
            if (e[32]) begin
                exp_q.push_back(e[31:0]);
                if (DS && (in_op == 4'd5 || in_op == 4'd7)) exp_q.push_back(32'h0);
            end else ill_seen = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_tuple(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                             input logic [15:0] imm, input logic [25:0] tgt);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; im_ready = 1'b0; base_load = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete(); got_d.delete(); got_a.delete();
    endtask

    // Present the current tuple until accepted (bounded).
    task automatic send(output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            ok = rdy_seen;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        im_ready = 1'b1;
        for (int k = 0; k < 100 && got_d.size() < n; k++) step();
        im_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 6;
        if (im_we !== 1'b0) begin n_fail++; $display("FAIL reset im_we got %b want 0", im_we); end
        if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL reset im_addr got %h want 00003000", im_addr); end
        if (im_wdata !== 32'h0) begin n_fail++; $display("FAIL reset im_wdata got %h want 0", im_wdata); end
        if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset word_cnt got %0d want 0", word_cnt); end
        if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset err_illegal got %b want 0", err_illegal); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        set_tuple(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks += 3;
        if (im_we !== 1'b1) begin n_fail++; $display("FAIL single im_we got %b want 1", im_we); end
        if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL single im_addr got %h want 00003000", im_addr); end
        if (im_wdata !== 32'h00221821) begin n_fail++; $display("FAIL single im_wdata got %h want 00221821", im_wdata); end
        im_ready = 1'b1;
        step();
        im_ready = 1'b0;
        n_checks += 2;
        if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL single word_cnt got %0d want 1", word_cnt); end
        if (im_we !== 1'b0) begin n_fail++; $display("FAIL single im_we_after got %b want 0", im_we); end
    endtask

    task automatic test_stream();
        logic [31:0] want[3] = '{32'h34011234, 32'h3C04ABCD, 32'h8C450004};
        do_reset();
        im_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: set_tuple(4'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
                1: set_tuple(4'd6, 5'd0, 5'd4, 5'd0, 16'hABCD, 26'h0);
                default: set_tuple(4'd3, 5'd2, 5'd5, 5'd0, 16'h0004, 26'h0);
            endcase
            step();
            n_checks++;
            if (rdy_seen !== 1'b1) begin n_fail++; $display("FAIL stream in_ready[%0d] got %b want 1", k, rdy_seen); end
        end
        drain(3);
        n_checks++;
        if (got_d.size() != 3) begin n_fail++; $display("FAIL stream count got %0d want 3", got_d.size()); end
        for (int k = 0; k < 3 && k < got_d.size(); k++) begin
            n_checks += 2;
            if (got_d[k] !== want[k]) begin n_fail++; $display("FAIL stream data[%0d] got %h want %h", k, got_d[k], want[k]); end
            if (got_a[k] !== 32'h3000 + 32'(4 * k)) begin n_fail++; $display("FAIL stream addr[%0d] got %h want %h", k, got_a[k], 32'h3000 + 32'(4 * k)); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        set_tuple(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        set_tuple(4'd4, 5'd3, 5'd6, 5'd0, 16'h0040, 26'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks += 4;
            if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL stall in_ready[%0d] got %b want 0", k, rdy_seen); end
            if (im_we !== 1'b1) begin n_fail++; $display("FAIL stall im_we[%0d] got %b want 1", k, im_we); end
            if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL stall im_addr[%0d] got %h want 00003000", k, im_addr); end
            if (im_wdata !== 32'h00E84823) begin n_fail++; $display("FAIL stall im_wdata[%0d] got %h want 00e84823", k, im_wdata); end
        end
        im_ready = 1'b1;
        send(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall accept got 0 want 1"); end
        drain(2);
        n_checks++;
        if (got_d.size() != 2) begin n_fail++; $display("FAIL stall count got %0d want 2", got_d.size()); end
        for (int k = 0; k < 2 && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall data[%0d] got %h want %h", k, got_d[k], exp_q[k]); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_tuple(4'd9, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks += 5;
        if (rdy_seen !== 1'b1) begin n_fail++; $display("FAIL illegal consumed got %b want 1", rdy_seen); end
        if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal pulse got %b want 1", err_illegal); end
        if (im_we !== 1'b0) begin n_fail++; $display("FAIL illegal im_we got %b want 0", im_we); end
        if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL illegal im_addr got %h want 00003000", im_addr); end
        if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL illegal word_cnt got %0d want 0", word_cnt); end
        step();
        n_checks++;
        if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal pulse_end got %b want 0", err_illegal); end
    endtask

    task automatic test_branch();
        bit ok1, ok2;
        logic [31:0] want[$];
        want = DS ? '{32'h1022FFFF, 32'h0, 32'h08000010, 32'h0} : '{32'h1022FFFF, 32'h08000010};
        do_reset();
        im_ready = 1'b1;
        set_tuple(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        send(ok1);
        set_tuple(4'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        send(ok2);
        drain(want.size());
        n_checks += 2;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL branch accept got %b%b want 11", ok1, ok2); end
        if (got_d.size() != want.size()) begin n_fail++; $display("FAIL branch count got %0d want %0d", got_d.size(), want.size()); end
        for (int k = 0; k < want.size() && k < got_d.size(); k++) begin
            n_checks += 2;
            if (got_d[k] !== want[k]) begin n_fail++; $display("FAIL branch data[%0d] got %h want %h", k, got_d[k], want[k]); end
            if (got_a[k] !== 32'h3000 + 32'(4 * k)) begin n_fail++; $display("FAIL branch addr[%0d] got %h want %h", k, got_a[k], 32'h3000 + 32'(4 * k)); end
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFF;
        set_tuple(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        base_addr = 32'h0000_0100;
        set_tuple(4'd2, 5'd1, 5'd1, 5'd0, 16'h00FF, 26'h0);
        step();
        base_load = 1'b0;
        n_checks += 2;
        if (im_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap base got %h want fffffffc", im_addr); end
        if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL wrap stalled_ready got %b want 0", rdy_seen); end
        im_ready = 1'b1;
        step();
        n_checks++;
        if (im_addr !== 32'h0) begin n_fail++; $display("FAIL wrap addr_after got %h want 0", im_addr); end
        drain(2);
        n_checks++;
        if (got_a.size() != 2) begin n_fail++; $display("FAIL wrap count got %0d want 2", got_a.size()); end
        else begin
            n_checks += 4;
            if (got_a[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap addr0 got %h want fffffffc", got_a[0]); end
            if (got_a[1] !== 32'h0) begin n_fail++; $display("FAIL wrap addr1 got %h want 0", got_a[1]); end
            if (got_d[0] !== exp_q[0]) begin n_fail++; $display("FAIL wrap data0 got %h want %h", got_d[0], exp_q[0]); end
            if (got_d[1] !== exp_q[1]) begin n_fail++; $display("FAIL wrap data1 got %h want %h", got_d[1], exp_q[1]); end
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        do_reset();
        n_checks += 3;
        if (im_we !== 1'b0) begin n_fail++; $display("FAIL midreset im_we got %b want 0", im_we); end
        if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL midreset im_addr got %h want 00003000", im_addr); end
        if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL midreset word_cnt got %0d want 0", word_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            im_ready = ($urandom_range(0, 2) != 0);
            set_tuple(($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                      5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            step();
            n_checks++;
            if (err_illegal !== ill_seen) begin n_fail++; $display("FAIL random err_illegal[%0d] got %b want %b", c, err_illegal, ill_seen); end
            if (stall_seen) begin
                n_checks++;
                if (!(im_we === 1'b1 && im_addr === stall_addr && im_wdata === stall_data)) begin
                    n_fail++;
                    $display("FAIL random hold[%0d] got we=%b %h/%h want 1 %h/%h", c, im_we, im_addr, im_wdata, stall_addr, stall_data);
                end
            end
        end
        drain(exp_q.size());
        n_checks += 2;
        if (got_d.size() != exp_q.size()) begin n_fail++; $display("FAIL random count got %0d want %0d", got_d.size(), exp_q.size()); end
        if (word_cnt !== 16'(exp_q.size())) begin n_fail++; $display("FAIL random word_cnt got %0d want %0d", word_cnt, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== exp_q[k] || got_a[k] !== 32'h3000 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL random write[%0d] got %h@%h want %h@%h", k, got_d[k], got_a[k], exp_q[k], 32'h3000 + 32'(4 * k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_illegal();
        test_branch();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
